// File: rtl/mcp_sequencer.sv
// rtl/mcp_sequencer.sv - program store and fetch/execute/update sequencer for the MCP core
// Holds a writable instruction memory and paces the core one instruction per three cycles.
module mcp_sequencer #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic          run,
  input  logic          step,
  input  logic          clear,
  input  logic [7:0]    next_address,
  output logic [7:0]    instruction,
  output logic          cpu_en,
  output logic [7:0]    pc,
  output logic          halted,
  output logic          addr_err,
  output logic [15:0]   instr_count
);

  localparam int         DEPTH = 2 ** AW;
  localparam logic [8:0] LIMIT = 9'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, UPDATE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  instr_q, instr_d;
  logic [7:0]  pc_q, pc_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;
  logic        single_q, single_d;
  logic [15:0] count_q, count_d;
  logic        mem_we;
  logic        na_oor;

  logic [7:0]  mem_q [DEPTH];

  assign na_oor = ({1'b0, next_address} >= LIMIT);

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    err_d    = err_q;
    single_d = single_q;
    count_d  = count_q;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        mem_we = load_en;
        // clear wins over run/step and keeps the sequencer parked
        if (clear) begin
          pc_d     = 8'h00;
          halted_d = 1'b0;
          err_d    = 1'b0;
        end else if (!halted_q && run) begin
          state_d  = FETCH;
          single_d = 1'b0;
        end else if (!halted_q && step) begin
          state_d  = FETCH;
          single_d = 1'b1;
        end
      end
      FETCH: begin
        instr_d = mem_q[pc_q[AW-1:0]];
        state_d = EXEC;
      end
      EXEC: begin
        if (count_q != 16'hFFFF) begin
          count_d = count_q + 16'd1;
        end
        state_d = UPDATE;
      end
      UPDATE: begin
        state_d  = IDLE;
        single_d = 1'b0;
        if (na_oor) begin
          err_d    = 1'b1;
          halted_d = 1'b1;
        end else if (next_address == pc_q) begin
          halted_d = 1'b1;
        end else begin
          pc_d = next_address;
          if (run && !single_q) begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      instr_q  <= 8'h00;
      pc_q     <= 8'h00;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      single_q <= 1'b0;
      count_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      single_q <= single_d;
      count_q  <= count_d;
    end
  end

  // program contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign cpu_en      = (state_q == EXEC);
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign addr_err    = err_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mcp_sequencer.sv
// tb/tb_mcp_sequencer.sv - self-checking bench for mcp_sequencer
// Step vectors from a constant table; run-mode traffic checked against an instruction-level model.
module tb_mcp_sequencer;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [7:0]    load_data = 8'h00;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          clear = 1'b0;
  logic [7:0]    next_address = 8'h00;
  logic [7:0]    instruction;
  logic          cpu_en;
  logic [7:0]    pc;
  logic          halted;
  logic          addr_err;
  logic [15:0]   instr_count;

  mcp_sequencer #(.AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .run          (run),
    .step         (step),
    .clear        (clear),
    .next_address (next_address),
    .instruction  (instruction),
    .cpu_en       (cpu_en),
    .pc           (pc),
    .halted       (halted),
    .addr_err     (addr_err),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // instruction-level reference state
  logic [7:0]  m_mem [32];
  logic [7:0]  m_pc;
  logic        m_halted;
  logic        m_err;
  logic [15:0] m_count;
  logic [7:0]  na_q [$];

  localparam int OP_STEP  = 0;
  localparam int OP_NONE  = 1;
  localparam int OP_CLEAR = 2;

  typedef struct {
    int          op;
    logic [7:0]  na;
    logic [7:0]  instr;
    logic [7:0]  pc;
    logic        halt;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc     = 8'h00;
    m_halted = 1'b0;
    m_err    = 1'b0;
    m_count  = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
    m_mem[a]  = d;
  endtask

  task automatic model_retire(input logic [7:0] na);
    if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
    if (na >= 8'd32) begin
      m_err    = 1'b1;
      m_halted = 1'b1;
    end else if (na == m_pc) begin
      m_halted = 1'b1;
    end else begin
      m_pc = na;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pc"},     32'(pc),          32'(m_pc));
    check({tag, "_halted"}, 32'(halted),      32'(m_halted));
    check({tag, "_err"},    32'(addr_err),    32'(m_err));
    check({tag, "_count"},  32'(instr_count), 32'(m_count));
  endtask

  // Runs with run held high, feeding next_address from na_q; run drops during the
  // EXEC of the last queued instruction or when the model predicts a halt.
  task automatic run_engine(input bit with_step, input bit guard_load, output logic [7:0] first_instr);
    int  last = -1;
    int  cyc = 0;
    bit  done = 0;
    logic [7:0] na;
    first_instr = 8'hxx;
    run  = 1'b1;
    step = with_step;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
      step = 1'b0;
      if (cpu_en) begin
        if (last < 0) first_instr = instruction;
        check("run_instr", 32'(instruction), 32'(m_mem[m_pc[4:0]]));
        if (last >= 0) check("run_spacing", 32'(cyc - last), 32'd3);
        last = cyc;
        if (guard_load) begin
          load_en   = 1'b1;
          load_addr = 5'd2;
          load_data = 8'hFF;
        end
        na = (na_q.size() > 0) ? na_q.pop_front() : 8'h00;
        next_address = na;
        model_retire(na);
        if (m_halted || na_q.size() == 0) begin
          run     = 1'b0;
          load_en = 1'b0;
          tick();
          tick();
          done = 1;
        end
      end
    end
    if (!done) check("run_timeout", 32'd0, 32'd1);
    run     = 1'b0;
    load_en = 1'b0;
    tick();
    check("run_idle_after", 32'(cpu_en), 32'd0);
    check_state("run");
  endtask

  initial begin
    logic [7:0] fi;
    bit seen;

    vecs[0] = '{OP_STEP,  8'h01, 8'h45, 8'h01, 1'b0, 1'b0, 16'd1};
    vecs[1] = '{OP_STEP,  8'h02, 8'h84, 8'h02, 1'b0, 1'b0, 16'd2};
    vecs[2] = '{OP_STEP,  8'h20, 8'hC2, 8'h02, 1'b1, 1'b1, 16'd3};
    vecs[3] = '{OP_NONE,  8'h00, 8'h00, 8'h02, 1'b1, 1'b1, 16'd3};
    vecs[4] = '{OP_CLEAR, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'd3};
    vecs[5] = '{OP_STEP,  8'h00, 8'h45, 8'h00, 1'b1, 1'b0, 16'd4};
    vecs[6] = '{OP_NONE,  8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 16'd4};
    vecs[7] = '{OP_CLEAR, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'd4};
    vecs[8] = '{OP_STEP,  8'h01, 8'h45, 8'h01, 1'b0, 1'b0, 16'd5};

    // reset and idle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_en) seen = 1;
    end
    check("idle_cpu_en", 32'(seen), 32'd0);
    check("idle_instr", 32'(instruction), 32'h00);
    check_state("idle");

    // load and run with a write attempt that must be ignored
    load(5'd0, 8'h45);
    load(5'd1, 8'h84);
    load(5'd2, 8'hC2);
    na_q = '{8'h01, 8'h02, 8'h02};
    run_engine(1'b0, 1'b1, fi);
    check("lr_first", 32'(fi), 32'h45);
    check("lr_pc", 32'(pc), 32'h02);
    check("lr_halted", 32'(halted), 32'd1);
    check("lr_count", 32'(instr_count), 32'd3);

    // table-driven single stepping, trap, ignored step and clear
    do_reset();
    for (int v = 0; v < 9; v++) begin
      case (vecs[v].op)
        OP_STEP: begin
          step = 1'b1;
          tick();
          step = 1'b0;
          check($sformatf("v%0d_fetch_en", v), 32'(cpu_en), 32'd0);
          tick();
          check($sformatf("v%0d_exec_en", v), 32'(cpu_en), 32'd1);
          check($sformatf("v%0d_instr", v), 32'(instruction), 32'(vecs[v].instr));
          next_address = vecs[v].na;
          tick();
          check($sformatf("v%0d_pulse", v), 32'(cpu_en), 32'd0);
          tick();
          tick();
          check($sformatf("v%0d_idle", v), 32'(cpu_en), 32'd0);
        end
        OP_NONE: begin
          step = 1'b1;
          tick();
          step = 1'b0;
          seen = 0;
          for (int i = 0; i < 5; i++) begin
            if (cpu_en) seen = 1;
            tick();
          end
          check($sformatf("v%0d_ignored", v), 32'(seen), 32'd0);
        end
        default: begin
          clear = 1'b1;
          tick();
          clear = 1'b0;
        end
      endcase
      check($sformatf("v%0d_pc", v), 32'(pc), 32'(vecs[v].pc));
      check($sformatf("v%0d_halted", v), 32'(halted), 32'(vecs[v].halt));
      check($sformatf("v%0d_err", v), 32'(addr_err), 32'(vecs[v].err));
      check($sformatf("v%0d_count", v), 32'(instr_count), 32'(vecs[v].cnt));
    end

    // run and step together: continuous execution, run dropped in last EXEC
    do_reset();
    na_q = '{8'h01, 8'h02, 8'h00};
    run_engine(1'b1, 1'b0, fi);
    check("rs_count", 32'(instr_count), 32'd3);
    check("rs_pc", 32'(pc), 32'h00);
    check("rs_halted", 32'(halted), 32'd0);

    // reset in the middle of EXEC
    run = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (cpu_en) seen = 1;
    end
    check("rst_reach_exec", 32'(seen), 32'd1);
    #1;
    reset = 1'b1;
    run   = 1'b0;
    #1;
    check("rst_async_en", 32'(cpu_en), 32'd0);
    check("rst_instr", 32'(instruction), 32'h00);
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_err", 32'(addr_err), 32'd0);
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    na_q = '{8'h05};
    run_engine(1'b0, 1'b0, fi);
    check("rst_mem_kept", 32'(fi), 32'h45);

    // randomized programs and control flow
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int a = 0; a < 32; a++) load(5'(a), 8'($urandom_range(0, 255)));
      na_q.delete();
      for (int k = 0; k < 20; k++) begin
        if ($urandom_range(0, 9) == 0) na_q.push_back(8'($urandom_range(32, 255)));
        else na_q.push_back(8'($urandom_range(0, 31)));
      end
      run_engine(1'b0, 1'b0, fi);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
